// File: rtl/riscv_core_div_ctrl.sv
// Iterative restoring divider for RV64 DIV/DIVU/REM/REMU and W forms; N+2 cycles accept-to-result (N=64 or 32).
// Single request in flight; ready only in IDLE, result held until resp_ready. Optional macro RISCV_DIV_EARLY_OUT_EN.
module riscv_core_div_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            i_div_out_clk,
    input  logic            i_div_out_rstn,
    input  logic            i_div_ctrl_valid,
    output logic            o_div_ctrl_ready,
    input  logic [XLEN-1:0] i_div_ctrl_srcA,
    input  logic [XLEN-1:0] i_div_ctrl_srcB,
    input  logic [1:0]      i_div_ctrl_control,
    input  logic            i_div_ctrl_isword,
    input  logic            i_div_ctrl_flush,
    output logic            o_div_ctrl_busy,
    output logic            o_div_ctrl_resp_valid,
    input  logic            i_div_ctrl_resp_ready,
    output logic [XLEN-1:0] o_div_ctrl_result,
    output logic            o_div_ctrl_div_by_zero,
    output logic            o_div_ctrl_overflow
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] srca_q, srca_d, srcb_q, srcb_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic            isword_q, isword_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            dbz_q, dbz_d, ovf_q, ovf_d;

    logic            is_signed, is_rem, div_zero, ovf;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg;
    logic [XLEN-1:0] q_fix, r_fix, res_sel, res_fix;
    logic [XLEN:0]   rs, diff;

    assign is_signed = ~ctrl_q[0];
    assign is_rem    = ctrl_q[1];

    // Operands are kept raw; W forms are extended from bit 31 before taking magnitudes.
    always_comb begin
        if (isword_q) begin
            a_ext   = {{(XLEN-32){is_signed & srca_q[31]}}, srca_q[31:0]};
            b_ext   = {{(XLEN-32){is_signed & srcb_q[31]}}, srcb_q[31:0]};
            min_neg = {{(XLEN-32){1'b1}}, 1'b1, 31'b0};
        end else begin
            a_ext   = srca_q;
            b_ext   = srcb_q;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    assign mag_a    = (is_signed && a_ext[XLEN-1]) ? -a_ext : a_ext;
    assign mag_b    = (is_signed && b_ext[XLEN-1]) ? -b_ext : b_ext;
    assign div_zero = (b_ext == '0);
    assign ovf      = is_signed && (a_ext == min_neg) && (b_ext == '1);

    assign rs   = {rem_q, quo_q[XLEN-1]};
    assign diff = rs - {1'b0, dvs_q};

    always_comb begin
        q_fix = (is_signed && (a_ext[XLEN-1] ^ b_ext[XLEN-1])) ? -quo_q : quo_q;
        r_fix = (is_signed && a_ext[XLEN-1]) ? -rem_q : rem_q;
        if (div_zero) begin
            q_fix = '1;
            r_fix = a_ext;
        end else if (ovf) begin
            q_fix = a_ext;
            r_fix = '0;
        end
        res_sel = is_rem ? r_fix : q_fix;
        res_fix = isword_q ? {{(XLEN-32){res_sel[31]}}, res_sel[31:0]} : res_sel;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        ctrl_d       = ctrl_q;
        isword_d     = isword_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        dbz_d        = dbz_q;
        ovf_d        = ovf_q;
        case (state_q)
            S_IDLE: if (i_div_ctrl_valid) begin
                srca_d   = i_div_ctrl_srcA;
                srcb_d   = i_div_ctrl_srcB;
                ctrl_d   = i_div_ctrl_control;
                isword_d = i_div_ctrl_isword;
                state_d  = S_PREP;
            end
            S_PREP: begin
                // W dividends sit in the upper half so the MSB-first shift always reads bit XLEN-1.
                quo_d   = isword_q ? {mag_a[31:0], 32'b0} : mag_a;
                rem_d   = '0;
                dvs_d   = mag_b;
                cnt_d   = isword_q ? 7'd32 : 7'd64;
                state_d = S_CALC;
`ifdef RISCV_DIV_EARLY_OUT_EN
                if (div_zero || ovf || (mag_a < mag_b)) begin
                    quo_d   = '0;
                    rem_d   = mag_a;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
`endif
            end
            S_CALC: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rs[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) state_d = S_DONE;
            end
            default: begin
                if (!resp_valid_q) begin
                    result_d     = res_fix;
                    dbz_d        = div_zero;
                    ovf_d        = ovf;
                    resp_valid_d = 1'b1;
                end else if (i_div_ctrl_resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
        endcase
        if (i_div_ctrl_flush && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_div_out_clk or negedge i_div_out_rstn) begin
        if (!i_div_out_rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            srca_q       <= '0;
            srcb_q       <= '0;
            ctrl_q       <= '0;
            isword_q     <= 1'b0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            dbz_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            ctrl_q       <= ctrl_d;
            isword_q     <= isword_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            dbz_q        <= dbz_d;
            ovf_q        <= ovf_d;
        end
    end

    assign o_div_ctrl_ready       = (state_q == S_IDLE);
    assign o_div_ctrl_busy        = (state_q != S_IDLE);
    assign o_div_ctrl_resp_valid  = resp_valid_q;
    assign o_div_ctrl_result      = result_q;
    assign o_div_ctrl_div_by_zero = dbz_q;
    assign o_div_ctrl_overflow    = ovf_q;
endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
// Directed bench for riscv_core_div_ctrl: results, flags, latency, flush, reset abort and response hold.
module tb_riscv_core_div_ctrl;
`ifdef RISCV_DIV_EARLY_OUT_EN
    localparam bit EO_EN = 1'b1;
`else
    localparam bit EO_EN = 1'b0;
`endif
    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [63:0] srca = '0, srcb = '0;
    logic [1:0]  ctrl = '0;
    logic        isword = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] result;
    logic        dbz, ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_core_div_ctrl #(.XLEN(64)) dut (
        .i_div_out_clk         (clk),
        .i_div_out_rstn        (rstn),
        .i_div_ctrl_valid      (valid),
        .o_div_ctrl_ready      (ready),
        .i_div_ctrl_srcA       (srca),
        .i_div_ctrl_srcB       (srcb),
        .i_div_ctrl_control    (ctrl),
        .i_div_ctrl_isword     (isword),
        .i_div_ctrl_flush      (flush),
        .o_div_ctrl_busy       (busy),
        .o_div_ctrl_resp_valid (resp_valid),
        .i_div_ctrl_resp_ready (resp_ready),
        .o_div_ctrl_result     (result),
        .o_div_ctrl_div_by_zero(dbz),
        .o_div_ctrl_overflow   (ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] c, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic fl);
        @(negedge clk);
        srca = a; srcb = b; ctrl = c; isword = w; valid = 1'b1; flush = fl;
        @(posedge clk);
        #1 valid = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!resp_valid && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check({tag, "_ready_after"}, 64'(ready), 64'd1);
        check({tag, "_rv_after"}, 64'(resp_valid), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [1:0] c, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_res,
                         input logic exp_dbz, input logic exp_ovf, input logic eo, input logic fl);
        int cyc;
        int exp_cyc;
        exp_cyc = (EO_EN && eo) ? 2 : (w ? 34 : 66);
        start(c, w, a, b, fl);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_resp(cyc);
        check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        handshake(tag);
    endtask

    initial begin
        int cyc;
        logic seen;
        logic [63:0] held;
        #12 check("rst_ready_low_time", 64'(resp_valid), 64'd0);
        @(negedge clk) rstn = 1'b1;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_flags", {62'd0, dbz, ovf}, 64'd0);

        do_op("div_m7_2", DIV, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("remw", REM, 1'b1, 64'h0000_0000_8000_0007, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("divu_z", DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        do_op("remu", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("divw", DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("divuw", DIVU, 1'b1, 64'h0000_0001_0000_000A, 64'd3, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("rem_m7_2", REM, 1'b0, -64'sd7, 64'd2, '1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("div_7_m2", DIV, 1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("remw_z", REM, 1'b1, 64'h0000_0000_8000_0001, 64'h5_0000_0000, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("divu_max", DIVU, 1'b0, '1, 64'd1, '1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("div_small", DIV, 1'b0, 64'd3, 64'd5, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("flush_valid", DIVU, 1'b0, 64'd50, 64'd5, 64'd10, 1'b0, 1'b0, 1'b0, 1'b1);

        // flush during the tenth CALC cycle
        start(DIV, 1'b0, 64'd100, 64'd10, 1'b0);
        repeat (10) @(posedge clk);
        #1 check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_ready", 64'(ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1 if (resp_valid) seen = 1'b1;
        end
        check("flush_no_resp", 64'(seen), 64'd0);
        do_op("after_flush", DIV, 1'b0, 64'd100, 64'd10, 64'd10, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset in the middle of an operation
        start(DIVU, 1'b0, 64'd99, 64'd9, 1'b0);
        repeat (20) @(posedge clk);
        #2 rstn = 1'b0;
        #1 check("rst_mid_ready", 64'(ready), 64'd1);
        @(negedge clk) rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1 if (resp_valid) seen = 1'b1;
        end
        check("rst_mid_no_resp", 64'(seen), 64'd0);

        // consumer stalls for five cycles in DONE
        start(DIVU, 1'b0, 64'd1000, 64'd10, 1'b0);
        wait_resp(cyc);
        check("hold_cycles", 64'(cyc), 64'd66);
        held = result;
        check("hold_result0", held, 64'd100);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", result, 64'd100);
            check("hold_ready_low", 64'(ready), 64'd0);
            check("hold_rv", 64'(resp_valid), 64'd1);
        end
        resp_ready = 1'b1;
        #1 check("hold_ready_hs_cycle", 64'(ready), 64'd0);
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check("hold_ready_after", 64'(ready), 64'd1);
        check("hold_rv_after", 64'(resp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
